avalon_master_mm_copy: RTL and testbench

//  Avalon-MM master that copies LENGTH consecutive 32-bit words from SRC_ADDR to DST_ADDR.

---
 rtl/avalon_master_mm_copy.sv | 173 +++++++++++++++++
 tb/tb_avalon_master_mm_copy.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_master_mm_copy.sv
// Avalon-MM copy master: moves LENGTH 32-bit words from a source to a destination
// address, one read then one write per word, a single transaction in flight.
module avalon_master_mm_copy #(
   parameter int          LEN_W    = 16,
   parameter logic [31:0] ADDR_INC = 32'd4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] length,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [LEN_W-1:0] word_count,
   output logic [31:0]      avm_address,
   output logic             avm_read,
   output logic             avm_write,
   output logic [31:0]      avm_writedata,
   input  logic [31:0]      avm_readdata,
   input  logic             avm_readdatavalid,
   input  logic             avm_waitrequest
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR_REQ  = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      src_q, src_d, dst_q, dst_d, data_q, data_d;
   logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
   logic             abort_pend_q, abort_pend_d, aborted_q, aborted_d;
   logic             done_q, done_d, busy_q, busy_d;
   logic             read_q, read_d, write_q, write_d;
   logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
   logic [LEN_W-1:0] cnt_inc_s;
   logic             in_job_s;

   assign cnt_inc_s = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
   assign in_job_s  = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT) || (state_q == S_WR_REQ);

   // Next-state and datapath decode; bus outputs are registered from the next state
   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      dst_d        = dst_q;
      data_d       = data_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      aborted_d    = aborted_q;
      abort_pend_d = abort_pend_q | (abort & in_job_s);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d     = src_addr;
               dst_d     = dst_addr;
               len_d     = length;
               cnt_d     = {LEN_W{1'b0}};
               aborted_d = 1'b0;
               state_d   = (length == {LEN_W{1'b0}}) ? S_DONE : S_RD_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD_REQ: begin
            if (!avm_waitrequest) begin
               state_d = S_RD_WAIT;
            end else begin
               state_d = S_RD_REQ;
            end
         end
         S_RD_WAIT: begin
            if (avm_readdatavalid) begin
               data_d  = avm_readdata;
               state_d = S_WR_REQ;
            end else begin
               state_d = S_RD_WAIT;
            end
         end
         S_WR_REQ: begin
            if (!avm_waitrequest) begin
               cnt_d = cnt_inc_s;
               src_d = src_q + ADDR_INC;
               dst_d = dst_q + ADDR_INC;
               // an abort raised in the accepting cycle still stops at this boundary
               if ((cnt_inc_s == len_q) || abort_pend_q || abort) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RD_REQ;
               end
            end else begin
               state_d = S_WR_REQ;
            end
         end
         S_DONE: begin
            aborted_d    = abort_pend_q;
            abort_pend_d = 1'b0;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d  = (state_d == S_RD_REQ) || (state_d == S_RD_WAIT) || (state_d == S_WR_REQ);
      read_d  = (state_d == S_RD_REQ);
      write_d = (state_d == S_WR_REQ);
      done_d  = (state_q == S_DONE);
      if (read_d) begin
         addr_d = src_d;
      end else if (write_d) begin
         addr_d = dst_d;
      end else begin
         addr_d = addr_q;
      end
      if (write_d) begin
         wdata_d = data_d;
      end else begin
         wdata_d = wdata_q;
      end
   end

   // State and output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         src_q        <= 32'd0;
         dst_q        <= 32'd0;
         data_q       <= 32'd0;
         len_q        <= {LEN_W{1'b0}};
         cnt_q        <= {LEN_W{1'b0}};
         abort_pend_q <= 1'b0;
         aborted_q    <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         data_q       <= data_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         abort_pend_q <= abort_pend_d;
         aborted_q    <= aborted_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         read_q       <= read_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign aborted       = aborted_q;
   assign word_count    = cnt_q;
   assign avm_address   = addr_q;
   assign avm_read      = read_q;
   assign avm_write     = write_q;
   assign avm_writedata = wdata_q;

endmodule

// File: tb/tb_avalon_master_mm_copy.sv
// Self-checking bench for avalon_master_mm_copy: a memory-slave model answers the bus,
// and each job's observed writes are compared with the copy the job should perform.
module tb_avalon_master_mm_copy;
   localparam int LEN_W = 16;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [31:0]      src_addr = 32'd0;
   logic [31:0]      dst_addr = 32'd0;
   logic [LEN_W-1:0] length = '0;
   logic             busy, done, aborted;
   logic [LEN_W-1:0] word_count;
   logic [31:0]      avm_address, avm_writedata;
   logic             avm_read, avm_write;
   logic [31:0]      avm_readdata = 32'd0;
   logic             avm_readdatavalid = 1'b0;
   logic             avm_waitrequest = 1'b0;

   avalon_master_mm_copy #(.LEN_W(LEN_W), .ADDR_INC(32'd4)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .src_addr(src_addr),
      .dst_addr(dst_addr), .length(length), .abort(abort), .busy(busy), .done(done),
      .aborted(aborted), .word_count(word_count), .avm_address(avm_address),
      .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
      .avm_waitrequest(avm_waitrequest)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // slave configuration and observations
   int          stall_cfg = 0;
   bit          stall_rand = 1'b0;
   bit          noise = 1'b0;
   int          lat_min = 1, lat_max = 1;
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          done_cnt = 0, done_wide = 0, req_cnt = 0, bus_viol = 0;
   logic [LEN_W-1:0] done_wc = '0;
   logic        done_ab = 1'b0;

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      int          len;
      int          stall;
      int          lat;
      int          exp_cnt;
   } vec_t;
   vec_t vecs[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   // Memory slave and bus-rule monitor, acting half a cycle away from the active edge
   initial begin
      bit p_rd, p_wr, p_wt, p_done, track;
      logic [31:0] p_addr, p_wdata, rd_pend;
      int stall_left, lat_cnt;
      p_rd = 0; p_wr = 0; p_wt = 0; p_done = 0; track = 0;
      p_addr = 0; p_wdata = 0; rd_pend = 0; stall_left = 0; lat_cnt = 0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            p_rd = 0; p_wr = 0; p_wt = 0; p_done = 0; track = 0; lat_cnt = 0;
            avm_waitrequest = 1'b0;
            avm_readdatavalid = 1'b0;
         end else begin
            if (p_rd && !p_wt) begin
               lat_cnt = $urandom_range(lat_max, lat_min);
               rd_pend = p_addr;
            end
            if (p_wr && !p_wt) begin
               wr_addr_q.push_back(p_addr);
               wr_data_q.push_back(p_wdata);
            end
            if (p_wt && (p_rd || p_wr) && (avm_read !== p_rd || avm_write !== p_wr ||
                avm_address !== p_addr || (p_wr && avm_writedata !== p_wdata)))
               bus_viol++;
            if (avm_read && avm_write) bus_viol++;
            if (avm_read || avm_write) req_cnt++;
            if (done) begin
               done_cnt++;
               done_wc = word_count;
               done_ab = aborted;
               if (p_done) done_wide++;
            end
            p_done = done;

            avm_readdatavalid = 1'b0;
            avm_readdata = noise ? $urandom : 32'd0;
            if (lat_cnt > 0) begin
               lat_cnt--;
               if (lat_cnt == 0) begin
                  avm_readdatavalid = 1'b1;
                  avm_readdata = mem_data(rd_pend);
               end
            end else if (noise && $urandom_range(3, 0) == 0) begin
               avm_readdatavalid = 1'b1;
            end

            if (avm_read || avm_write) begin
               if (!track) begin
                  stall_left = stall_rand ? $urandom_range(3, 0) : stall_cfg;
                  track = 1;
               end
               if (stall_left > 0) begin
                  avm_waitrequest = 1'b1;
                  stall_left--;
               end else begin
                  avm_waitrequest = 1'b0;
                  track = 0;
               end
            end else begin
               avm_waitrequest = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            end
            p_rd = avm_read; p_wr = avm_write; p_wt = avm_waitrequest;
            p_addr = avm_address; p_wdata = avm_writedata;
         end
      end
   end

   task automatic launch_job(input logic [31:0] s, input logic [31:0] d, input int len);
      wr_addr_q.delete();
      wr_data_q.delete();
      done_cnt = 0; done_wide = 0; req_cnt = 0; bus_viol = 0;
      @(negedge clock);
      src_addr = s; dst_addr = d; length = LEN_W'(len); start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic finish_job(input string name, input logic [31:0] s, input logic [31:0] d,
                             input int exp_cnt, input bit exp_ab);
      int cyc = 0;
      int req_at_done;
      int bad = 0;
      while (done_cnt == 0 && cyc < 800) begin
         @(negedge clock);
         cyc++;
      end
      check({name, ".done_seen"}, (done_cnt > 0) ? 1 : 0, 1);
      req_at_done = req_cnt;
      repeat (5) @(negedge clock);
      check({name, ".done_pulses"}, done_cnt, 1);
      check({name, ".bus_rules"}, bus_viol + done_wide, 0);
      check({name, ".word_count"}, done_wc, exp_cnt);
      check({name, ".aborted"}, done_ab, exp_ab);
      check({name, ".writes"}, wr_addr_q.size(), exp_cnt);
      for (int i = 0; i < wr_addr_q.size() && i < exp_cnt; i++) begin
         if (wr_addr_q[i] !== d + 32'(4 * i) || wr_data_q[i] !== mem_data(s + 32'(4 * i))) bad++;
      end
      check({name, ".write_content"}, bad, 0);
      check({name, ".quiet_after_done"}, req_cnt, req_at_done);
      check({name, ".idle_busy"}, busy, 0);
   endtask

   task automatic wait_write(input string name);
      int cyc = 0;
      while (!avm_write && cyc < 200) begin
         @(negedge clock);
         cyc++;
      end
      check({name, ".write_reached"}, avm_write, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{src: 32'h0000_0100, dst: 32'h0000_0200, len: 3, stall: 0, lat: 1, exp_cnt: 3};
      vecs[1] = '{src: 32'h0000_0100, dst: 32'h0000_0200, len: 3, stall: 2, lat: 1, exp_cnt: 3};
      vecs[2] = '{src: 32'h0000_0300, dst: 32'h0000_0400, len: 0, stall: 0, lat: 1, exp_cnt: 0};
      vecs[3] = '{src: 32'hFFFF_FFF8, dst: 32'hFFFF_FFFC, len: 3, stall: 1, lat: 2, exp_cnt: 3};
      vecs[4] = '{src: 32'h0001_0000, dst: 32'h0002_0000, len: 5, stall: 1, lat: 3, exp_cnt: 5};

      repeat (3) @(negedge clock);
      check("reset.ctrl", {busy, done, aborted, avm_read, avm_write}, 5'd0);
      check("reset.bus", {avm_address, avm_writedata}, 64'd0);
      check("reset.word_count", word_count, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      for (int i = 0; i < 5; i++) begin
         stall_cfg = vecs[i].stall;
         lat_min = vecs[i].lat;
         lat_max = vecs[i].lat;
         launch_job(vecs[i].src, vecs[i].dst, vecs[i].len);
         finish_job($sformatf("vec%0d", i), vecs[i].src, vecs[i].dst, vecs[i].exp_cnt, 1'b0);
      end

      // zero-length job: done two cycles after the start cycle, no bus traffic
      stall_cfg = 0; lat_min = 1; lat_max = 1;
      launch_job(32'h0000_0500, 32'h0000_0600, 0);
      check("len0.early", done, 0);
      @(negedge clock);
      check("len0.done_time", done, 1);
      finish_job("len0", 32'h0000_0500, 32'h0000_0600, 0, 1'b0);
      check("len0.no_requests", req_cnt, 0);

      // second start during the first write is ignored
      launch_job(32'h0000_0400, 32'h0000_0500, 4);
      wait_write("restart");
      src_addr = 32'h0000_0900; length = LEN_W'(2); start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      finish_job("restart", 32'h0000_0400, 32'h0000_0500, 4, 1'b0);

      // abort during the read wait of word 2
      begin
         int seen = 0;
         int cyc = 0;
         launch_job(32'h0000_1000, 32'h0000_2000, 8);
         while (seen < 2 && cyc < 200) begin
            if (busy && !avm_read && !avm_write) seen++;
            if (seen < 2) begin
               @(negedge clock);
               cyc++;
            end
         end
         check("abort.rd_wait_reached", seen, 2);
         abort = 1'b1;
         @(negedge clock);
         abort = 1'b0;
         finish_job("abort", 32'h0000_1000, 32'h0000_2000, 2, 1'b1);
      end

      // abort while idle leaves the next job untouched
      abort = 1'b1;
      repeat (2) @(negedge clock);
      abort = 1'b0;
      launch_job(32'h0000_1100, 32'h0000_2100, 2);
      finish_job("idle_abort", 32'h0000_1100, 32'h0000_2100, 2, 1'b0);

      // reset in the middle of a write
      launch_job(32'h0000_3000, 32'h0000_3100, 4);
      wait_write("rst");
      reset_n = 1'b0;
      #1;
      check("rst.async_drop", {avm_write, avm_read, busy}, 3'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      check("rst.no_done", done_cnt, 0);
      check("rst.word_count", word_count, 0);
      launch_job(32'h0000_3000, 32'h0000_3100, 4);
      finish_job("after_rst", 32'h0000_3000, 32'h0000_3100, 4, 1'b0);

      // randomised jobs: random stalls, latencies, spurious strobes and wrapping addresses
      stall_rand = 1'b1; noise = 1'b1; lat_min = 1; lat_max = 4;
      for (int j = 0; j < 10; j++) begin
         logic [31:0] s, d;
         int len;
         s = $urandom & 32'hFFFF_FFFC;
         d = $urandom & 32'hFFFF_FFFC;
         if (j == 0) s = 32'hFFFF_FFF0;
         len = $urandom_range(6, 1);
         launch_job(s, d, len);
         finish_job($sformatf("rand%0d", j), s, d, len, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
